// File: rtl/idli_alu_ser_m.sv
// idli bit-serial ALU: processes a WORD_W-bit op as SLICE_W-bit slices, LSB first.
// Produces registered result slices and whole-word Z/C/N/V flags on completion.
module idli_alu_ser_m #(
  parameter int SLICE_W = 4,
  parameter int WORD_W  = 16
) (
  input  logic               i_alu_gck,
  input  logic               i_alu_rst_n,
  input  logic               i_alu_start,
  input  logic               i_alu_vld,
  input  logic [2:0]         i_alu_op,
  input  logic [SLICE_W-1:0] i_alu_lhs,
  input  logic [SLICE_W-1:0] i_alu_rhs,
  output logic [SLICE_W-1:0] o_alu_out,
  output logic               o_alu_out_vld,
  output logic               o_alu_done,
  output logic               o_alu_busy,
  output logic               o_alu_flag_z,
  output logic               o_alu_flag_c,
  output logic               o_alu_flag_n,
  output logic               o_alu_flag_v
);

  localparam int NSL = WORD_W / SLICE_W;
  localparam int CW  = $clog2(NSL) + 1;
  localparam int M   = SLICE_W - 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [2:0]    op_q;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          zacc;

  logic               is_start;
  logic               acc;
  logic               last;
  logic               arith;
  logic               cin;
  logic               cout;
  logic               ovf;
  logic               zn;
  logic [2:0]         op_c;
  logic [SLICE_W-1:0] b;
  logic [SLICE_W-1:0] res;
  logic [SLICE_W:0]   sum;

  always_comb begin
    is_start = i_alu_vld & i_alu_start;
    acc      = i_alu_vld & (i_alu_start | (state == RUN));
    op_c     = is_start ? i_alu_op : op_q;
    arith    = op_c < 3'd3;
    b        = (op_c == 3'd1) ? ~i_alu_rhs : i_alu_rhs;
    // Slice 0 seeds the carry chain from the op; later slices use the carry register
    if (is_start)
      cin = (op_c == 3'd1) | ((op_c == 3'd2) & o_alu_flag_c);
    else
      cin = carry;
    sum = {1'b0, i_alu_lhs} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
    unique case (1'b1)
      arith:           res = sum[M:0];
      (op_c == 3'd3):  res = i_alu_lhs & i_alu_rhs;
      (op_c == 3'd4):  res = i_alu_lhs | i_alu_rhs;
      default:         res = i_alu_lhs ^ i_alu_rhs;
    endcase
    cout = arith & sum[SLICE_W];
    ovf  = arith & (i_alu_lhs[M] == b[M]) & (res[M] != i_alu_lhs[M]);
    zn   = (res == '0) & (is_start | zacc);
    last = is_start ? (NSL == 1) : (cnt == CW'(NSL - 1));
  end

  always_ff @(posedge i_alu_gck or negedge i_alu_rst_n) begin
    if (!i_alu_rst_n) begin
      state         <= IDLE;
      op_q          <= '0;
      cnt           <= '0;
      carry         <= 1'b0;
      zacc          <= 1'b0;
      o_alu_out     <= '0;
      o_alu_out_vld <= 1'b0;
      o_alu_done    <= 1'b0;
      o_alu_busy    <= 1'b0;
      o_alu_flag_z  <= 1'b0;
      o_alu_flag_c  <= 1'b0;
      o_alu_flag_n  <= 1'b0;
      o_alu_flag_v  <= 1'b0;
    end else begin
      o_alu_out_vld <= acc;
      o_alu_done    <= acc & last;
      if (acc) begin
        o_alu_out <= res;
        carry     <= cout;
        zacc      <= zn;
        if (is_start) op_q <= i_alu_op;
        if (last) begin
          state        <= IDLE;
          o_alu_busy   <= 1'b0;
          cnt          <= '0;
          o_alu_flag_z <= zn;
          o_alu_flag_c <= cout;
          o_alu_flag_n <= res[M];
          o_alu_flag_v <= ovf;
        end else begin
          state      <= RUN;
          o_alu_busy <= 1'b1;
          cnt        <= is_start ? CW'(1) : cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_idli_alu_ser_m.sv
// Randomized self-checking bench for idli_alu_ser_m in three slice/word configs.
// Expected results come from a whole-word arithmetic model.
module tb_idli_alu_ser_m;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] st = '0;
  logic [2:0] vl = '0;
  logic [2:0] op = '0;
  logic [7:0] lhs = '0;
  logic [7:0] rhs = '0;

  wire [3:0] o0;
  wire       o1;
  wire [7:0] o2;
  wire [2:0] ov, dn, bz, fz, fc, fn, fv;

  int   nchk = 0;
  int   nerr = 0;
  logic cflag [3];

  always #5 clk = ~clk;

  idli_alu_ser_m #(.SLICE_W(4), .WORD_W(16)) u0 (
    .i_alu_gck(clk), .i_alu_rst_n(rst_n),
    .i_alu_start(st[0]), .i_alu_vld(vl[0]), .i_alu_op(op),
    .i_alu_lhs(lhs[3:0]), .i_alu_rhs(rhs[3:0]),
    .o_alu_out(o0), .o_alu_out_vld(ov[0]), .o_alu_done(dn[0]),
    .o_alu_busy(bz[0]), .o_alu_flag_z(fz[0]), .o_alu_flag_c(fc[0]),
    .o_alu_flag_n(fn[0]), .o_alu_flag_v(fv[0]));

  idli_alu_ser_m #(.SLICE_W(1), .WORD_W(8)) u1 (
    .i_alu_gck(clk), .i_alu_rst_n(rst_n),
    .i_alu_start(st[1]), .i_alu_vld(vl[1]), .i_alu_op(op),
    .i_alu_lhs(lhs[0:0]), .i_alu_rhs(rhs[0:0]),
    .o_alu_out(o1), .o_alu_out_vld(ov[1]), .o_alu_done(dn[1]),
    .o_alu_busy(bz[1]), .o_alu_flag_z(fz[1]), .o_alu_flag_c(fc[1]),
    .o_alu_flag_n(fn[1]), .o_alu_flag_v(fv[1]));

  idli_alu_ser_m #(.SLICE_W(8), .WORD_W(8)) u2 (
    .i_alu_gck(clk), .i_alu_rst_n(rst_n),
    .i_alu_start(st[2]), .i_alu_vld(vl[2]), .i_alu_op(op),
    .i_alu_lhs(lhs), .i_alu_rhs(rhs),
    .o_alu_out(o2), .o_alu_out_vld(ov[2]), .o_alu_done(dn[2]),
    .o_alu_busy(bz[2]), .o_alu_flag_z(fz[2]), .o_alu_flag_c(fc[2]),
    .o_alu_flag_n(fn[2]), .o_alu_flag_v(fv[2]));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sw_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 8;
  endfunction

  function automatic int ww_of(input int k);
    return (k == 0) ? 16 : 8;
  endfunction

  function automatic logic [7:0] out_of(input int k);
    if (k == 0) return {4'b0, o0};
    if (k == 1) return {7'b0, o1};
    return o2;
  endfunction

  task automatic drive(input int k, input logic s, input logic [2:0] o,
                       input logic [7:0] l, input logic [7:0] r);
    @(negedge clk);
    st = '0;
    vl = '0;
    st[k] = s;
    vl[k] = 1'b1;
    op = o;
    lhs = l;
    rhs = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      st = '0;
      vl = '0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input int k, input logic [2:0] o,
                        input logic [15:0] a_in, input logic [15:0] b_in,
                        input int stall_at, input int stalls);
    int          sw;
    int          ww;
    int          nsl;
    logic [15:0] m, a, b, bb, r;
    logic [16:0] s;
    logic [7:0]  sm, es;
    logic        c, v, cin;
    sw  = sw_of(k);
    ww  = ww_of(k);
    nsl = ww / sw;
    m   = 16'((32'd1 << ww) - 1);
    sm  = 8'((32'd1 << sw) - 1);
    a   = a_in & m;
    b   = b_in & m;
    bb  = (o == 3'd1) ? (~b & m) : b;
    cin = (o == 3'd1) ? 1'b1 : (o == 3'd2) ? cflag[k] : 1'b0;
    if (o < 3'd3) begin
      s = {1'b0, a} + {1'b0, bb} + 17'(cin);
      r = s[15:0] & m;
      c = s[ww];
      v = (a[ww-1] == bb[ww-1]) && (r[ww-1] != a[ww-1]);
    end else begin
      r = (o == 3'd3) ? (a & b) : (o == 3'd4) ? (a | b) : (a ^ b);
      c = 1'b0;
      v = 1'b0;
    end
    for (int i = 0; i < nsl; i++) begin
      drive(k, i == 0, o, 8'(a >> (i * sw)) & sm, 8'(b >> (i * sw)) & sm);
      es = 8'(r >> (i * sw)) & sm;
      check($sformatf("vld k%0d s%0d", k, i), ov[k], 1);
      check($sformatf("out k%0d s%0d", k, i), out_of(k), es);
      check($sformatf("done k%0d s%0d", k, i), dn[k], i == nsl - 1);
      if (i < nsl - 1) check($sformatf("busy k%0d s%0d", k, i), bz[k], 1);
      if (i == stall_at) begin
        for (int j = 0; j < stalls; j++) begin
          idle(1);
          check("stall_vld", ov[k], 0);
          check("stall_out", out_of(k), es);
          check("stall_done", dn[k], 0);
        end
      end
    end
    check($sformatf("z k%0d op%0d", k, o), fz[k], r == 16'h0);
    check($sformatf("c k%0d op%0d", k, o), fc[k], c);
    check($sformatf("n k%0d op%0d", k, o), fn[k], r[ww-1]);
    check($sformatf("v k%0d op%0d", k, o), fv[k], v);
    cflag[k] = c;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_out"}, {o0, o1, o2}, 0);
    check({tag, "_ctl"}, {ov, dn, bz}, 0);
    check({tag, "_flg"}, {fz, fc, fn, fv}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout nerr=%0d nchk=%0d", nerr, nchk);
    $fatal(1);
  end

  initial begin
    int k;
    int nsl;
    for (int i = 0; i < 3; i++) cflag[i] = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 3'd0, 16'h1234, 16'h0FFF, -1, 0);
    run_op(0, 3'd1, 16'h0005, 16'h0005, -1, 0);
    run_op(0, 3'd0, 16'h7FFF, 16'h0001, -1, 0);
    run_op(0, 3'd0, 16'hFFFF, 16'h0001, -1, 0);
    run_op(0, 3'd2, 16'h0000, 16'h0000, -1, 0);
    idle(1);
    run_op(0, 3'd0, 16'h1234, 16'h0FFF, 1, 2);

    drive(0, 1'b1, 3'd3, 8'hF, 8'h0);
    check("abort_done0", dn[0], 0);
    drive(0, 1'b0, 3'd3, 8'hF, 8'hF);
    check("abort_done1", dn[0], 0);
    run_op(0, 3'd5, 16'hAAAA, 16'h5555, -1, 0);

    drive(0, 1'b1, 3'd0, 8'h4, 8'hF);
    drive(0, 1'b0, 3'd0, 8'h3, 8'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midop_rst");
    for (int i = 0; i < 3; i++) cflag[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b0, 3'd0, 8'h1, 8'h1);
    check("nostart_vld", ov[0], 0);
    check("nostart_busy", bz[0], 0);
    idle(1);
    run_op(0, 3'd0, 16'h1234, 16'h0FFF, -1, 0);

    run_op(1, 3'd0, 16'h0034, 16'h000F, -1, 0);
    run_op(1, 3'd0, 16'h007F, 16'h0001, 3, 2);
    run_op(2, 3'd0, 16'h0034, 16'h000F, -1, 0);
    run_op(2, 3'd0, 16'h00FF, 16'h0001, -1, 0);
    run_op(2, 3'd2, 16'h0010, 16'h0020, 0, 1);

    repeat (80) begin
      k   = $urandom_range(0, 2);
      nsl = ww_of(k) / sw_of(k);
      run_op(k, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, nsl - 1) : -1,
             $urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) idle(1);
    end

    idle(1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/idli_alu_ser_m.md
# idli_alu_ser_m

Parametrised bit-serial ALU for the idli core, the next generation of the nibble-serial ALU. It processes a WORD_W-bit operation as WORD_W/SLICE_W slices, least-significant slice first. It owns the slice counter, carry chain and op latch internally, and produces registered result slices plus whole-word Z/C/N/V flags. It sits between the register-file read path and the writeback/flag logic of the execute stage.

## Interface
- SLICE_W, 4, bits processed per accepted slice; must be at least 1.
- WORD_W, 16, operation width; WORD_W % SLICE_W == 0 is required. NSL = WORD_W/SLICE_W ≥ 1.
- i_alu_gck  in  1  clock; all state changes on its rising edge.
- i_alu_rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- i_alu_start  in  1  the current slice is slice 0 of a new operation.
- i_alu_vld  in  1  lhs/rhs slice valid this cycle.
- i_alu_op  in  3  op code, sampled only on an accepted start: 0 ADD, 1 SUB, 2 ADC, 3 AND, 4 OR, 5 XOR, 6/7 reserved (behave as XOR).
- i_alu_lhs, i_alu_rhs  in  SLICE_W  operand slices.
- o_alu_out  out  SLICE_W  registered result slice.
- o_alu_out_vld  out  1  o_alu_out holds a new slice this cycle.
- o_alu_done  out  1  single-cycle pulse with the final result slice; flags update in the same cycle.
- o_alu_busy  out  1  an operation is in progress; slices 1..NSL-1 are still expected.
- o_alu_flag_z, o_alu_flag_c, o_alu_flag_n, o_alu_flag_v  out  1 each  flags of the last completed op.

## Operation
- States: IDLE and RUN; the slice counter is ceil(log2(NSL))+1 bits wide.
- Accept rule: a slice is accepted when i_alu_vld=1. In IDLE an accepted slice also needs i_alu_start=1; otherwise it is ignored and produces no output.
- On an accepted start:
  - latch op, set counter=0, process the slice.
  - Carry-in: ADD 0; SUB 1 (rhs inverted); ADC the stored o_alu_flag_c.
  - If NSL>1, go to RUN; otherwise complete immediately.
- RUN:
  - each accepted slice uses the latched op and the internal carry register, then increments the counter.
  - The slice with counter==NSL-1 completes the op and returns to IDLE.
- Abort: i_alu_start=1 with i_alu_vld=1 in RUN abandons the current op without done or flag update. It restarts as slice 0 with the new op.
- Arithmetic: per slice, {cout,out} = lhs + (SUB ? ~rhs : rhs) + cin. The carry register takes cout.
- Logic ops: carry is forced to 0.
- Z accumulator: initialised to (out==0) on slice 0, ANDed with (out==0) on each later slice.
- On completion, flags are registered:
  - Z = accumulated zero.
  - C = final cout for ADD/SUB/ADC (SUB: C=1 means no borrow); 0 for logic ops.
  - N = out[SLICE_W-1] of the final slice.
  - V = signed overflow from the final slice (carry into MSB XOR carry out) for arithmetic ops; 0 for logic ops.
- Flags hold their value between completions; they are not changed by an aborted op.
- i_alu_vld=0 in RUN is a stall: all state holds and o_alu_out keeps its last value.

## Timing
- Latency: one cycle from an accepted slice to o_alu_out/o_alu_out_vld. o_alu_done and the flags follow the final slice by one cycle.
- o_alu_out_vld is high exactly in the cycles after accepted slices.
- Back-to-back ops: start may be asserted in the cycle immediately after the final slice; no bubble.
- o_alu_busy is high from the cycle after an accepted start (NSL>1) until the cycle after the final slice.
- Reset clears all of the following asynchronously; a reset mid-op discards the op:
  - o_alu_out=0, o_alu_out_vld=0, o_alu_done=0, o_alu_busy=0
  - all flags=0
  - carry, counter and Z accumulator = 0; state = IDLE.
- Reset release: the first edge may accept a start.

## Test plan
- ADD 0x1234+0x0FFF (SLICE_W=4, WORD_W=16), 4 consecutive slices -> out slices 3,3,2,2 (0x2233). Done 1 cycle after slice 3; Z=0 C=0 N=0 V=0.
- SUB 0x0005-0x0005 -> 0x0000, Z=1 C=1 N=0 V=0. Then ADD 0x7FFF+0x0001 -> 0x8000, N=1 V=1 C=0.
- ADD 0xFFFF+0x0001 -> 0x0000, C=1 Z=1. Then ADC 0x0000+0x0000 -> 0x0001, C=0.
- ADD with i_alu_vld low for 2 cycles after slice 1 -> same result. Done is delayed 2 cycles, o_alu_out_vld is low for those cycles, and o_alu_out holds.
- Start AND 0xFFFF/0x00F0, abort at slice 2 with start XOR 0xAAAA^0x5555 -> no done for the AND, XOR result 0xFFFF, Z=0 C=0 V=0 N=1.
- Drive rst_n low mid-ADD -> all outputs 0 immediately. Vld without start after reset produces no output; a fresh op completes normally. Repeat the ADD case with SLICE_W=1/WORD_W=8 and SLICE_W=8/WORD_W=8.
